// File: rtl/lsu_pkg.sv
// Shared encodings for the memory-stage load/store unit.
package lsu_pkg;

    localparam int DEPTH_DFLT = 256;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic [1:0] {
        S_IDLE,
        S_LD_DATA,
        S_RMW,
        S_RESP
    } lsu_state_e;

endpackage

// File: rtl/load_store_unit_fmt.sv
// Load extract/extend and sub-word store merge for the load/store unit.
module lsu_fmt
    import lsu_pkg::*;
(
    input  logic [1:0]  size,
    input  logic        is_unsigned,
    input  logic [31:0] mem_do,
    input  logic [31:0] wdata,
    output logic [31:0] load_data,
    output logic [31:0] store_data
);

    always_comb begin
        load_data  = mem_do;
        store_data = wdata;
        case (size)
            SZ_BYTE: begin
                load_data  = {{24{~is_unsigned & mem_do[7]}}, mem_do[7:0]};
                store_data = {mem_do[31:8], wdata[7:0]};
            end
            SZ_HALF: begin
                load_data  = {{16{~is_unsigned & mem_do[15]}}, mem_do[15:0]};
                store_data = {mem_do[31:16], wdata[15:0]};
            end
            default: begin
                load_data  = mem_do;
                store_data = wdata;
            end
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Memory-stage load/store unit: sub-word accesses via whole-word memory.
// Optional alignment faults with `define LSU_ALIGN_CHECK_EN.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int DEPTH  = DEPTH_DFLT,
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    output logic [31:0]       resp_rdata,
    output logic              resp_err,
    output logic [ADDR_W-1:0] mem_ra,
    output logic [ADDR_W-1:0] mem_wa,
    output logic [31:0]       mem_di,
    output logic              mem_wr,
    input  logic [31:0]       mem_do
);

    lsu_state_e        state_q, state_d;
    logic [1:0]        size_q, size_d;
    logic              uns_q, uns_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [31:0]       rdata_q, rdata_d;
    logic              err_q, err_d;
    logic              valid_q, valid_d;
    logic [ADDR_W-1:0] ra_q, wa_q;
    logic [31:0]       di_q;

    logic        accept, legal, align_ok;
    logic        word_st, rd_req;
    logic [31:0] load_data, store_data;

    lsu_fmt u_fmt (
        .size        (size_q),
        .is_unsigned (uns_q),
        .mem_do      (mem_do),
        .wdata       (wdata_q),
        .load_data   (load_data),
        .store_data  (store_data)
    );

`ifdef LSU_ALIGN_CHECK_EN
    assign align_ok = !((req_size == SZ_HALF && req_addr[0]) ||
                        (req_size == SZ_WORD && req_addr[1:0] != 2'b00));
`else
    assign align_ok = 1'b1;
`endif

    // Memory always moves 4 bytes, so even byte accesses stop at DEPTH-4.
    assign legal   = (req_size != 2'b11) &&
                     (req_addr <= ADDR_W'(DEPTH - 4)) && align_ok;
    assign accept  = req_valid && (state_q == S_IDLE) && !rst;
    assign word_st = accept && legal && req_we && (req_size == SZ_WORD);
    assign rd_req  = accept && legal && !(req_we && (req_size == SZ_WORD));

    assign req_ready  = (state_q == S_IDLE);
    assign resp_valid = valid_q;
    assign resp_rdata = rdata_q;
    assign resp_err   = err_q;

    assign mem_ra = rd_req ? req_addr : ra_q;
    assign mem_wr = word_st || (state_q == S_RMW);

    always_comb begin
        mem_wa = wa_q;
        mem_di = di_q;
        if (word_st) begin
            mem_wa = req_addr;
            mem_di = req_wdata;
        end else if (state_q == S_RMW) begin
            mem_wa = addr_q;
            mem_di = store_data;
        end
    end

    always_comb begin
        state_d = state_q;
        size_d  = size_q;
        uns_d   = uns_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        unique case (state_q)
            S_IDLE: begin
                if (accept) begin
                    size_d  = req_size;
                    uns_d   = req_unsigned;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    err_d   = !legal;
                    rdata_d = 32'h0;
                    if (!legal || word_st) state_d = S_RESP;
                    else if (req_we)       state_d = S_RMW;
                    else                   state_d = S_LD_DATA;
                end
            end
            S_LD_DATA: begin
                rdata_d = load_data;
                state_d = S_RESP;
            end
            S_RMW:   state_d = S_RESP;
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        valid_d = (state_d == S_RESP);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            size_q  <= SZ_BYTE;
            uns_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= 32'h0;
            rdata_q <= 32'h0;
            err_q   <= 1'b0;
            valid_q <= 1'b0;
            ra_q    <= '0;
            wa_q    <= '0;
            di_q    <= 32'h0;
        end else begin
            state_q <= state_d;
            size_q  <= size_d;
            uns_q   <= uns_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            valid_q <= valid_d;
            ra_q    <= mem_ra;
            wa_q    <= mem_wa;
            di_q    <= mem_di;
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit with a byte-array reference model.
module tb_load_store_unit;
    import lsu_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready, req_we, req_unsigned;
    logic [1:0]  req_size;
    logic [31:0] req_addr, req_wdata;
    logic        resp_valid, resp_err, mem_wr;
    logic [31:0] resp_rdata, mem_ra, mem_wa, mem_di, mem_do;

    int total = 0;
    int bad   = 0;
    int wr_cnt = 0;
    logic [31:0] last_di = 32'h0;

    logic [7:0] dmem [256] = '{default: 8'h00};
    logic [7:0] rmem [256] = '{default: 8'h00};

    always #5 clk = ~clk;

    load_store_unit #(.DEPTH(256), .ADDR_W(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_we       (req_we),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .resp_valid   (resp_valid),
        .resp_rdata   (resp_rdata),
        .resp_err     (resp_err),
        .mem_ra       (mem_ra),
        .mem_wa       (mem_wa),
        .mem_di       (mem_di),
        .mem_wr       (mem_wr),
        .mem_do       (mem_do)
    );

    // The data memory attached to the DUT: 4-byte window, registered read.
    always @(posedge clk) begin
        if (mem_wr) begin
            for (int k = 0; k < 4; k++)
                dmem[(mem_wa + k) & 255] <= mem_di[8*k +: 8];
            wr_cnt  <= wr_cnt + 1;
            last_di <= mem_di;
        end
        mem_do <= {dmem[(mem_ra + 3) & 255], dmem[(mem_ra + 2) & 255],
                   dmem[(mem_ra + 1) & 255], dmem[mem_ra & 255]};
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ref_word(input int a);
        return {rmem[(a + 3) & 255], rmem[(a + 2) & 255],
                rmem[(a + 1) & 255], rmem[a & 255]};
    endfunction

    function automatic logic [31:0] dut_word(input int a);
        return {dmem[(a + 3) & 255], dmem[(a + 2) & 255],
                dmem[(a + 1) & 255], dmem[a & 255]};
    endfunction

    function automatic bit ref_legal(input logic [1:0] sz, input int a);
        bit ok;
        ok = (sz != 2'b11) && (a <= 252);
`ifdef LSU_ALIGN_CHECK_EN
        if (sz == 2'b01 && (a % 2) != 0) ok = 0;
        if (sz == 2'b10 && (a % 4) != 0) ok = 0;
`endif
        return ok;
    endfunction

    task automatic run(input string tag, input logic we, input logic [1:0] sz,
                       input logic uns, input int a, input logic [31:0] wd);
        bit          ok;
        int          nbytes, exp_lat, exp_wr, lat, w0;
        logic [31:0] mask, w, exp_rd;
        ok     = ref_legal(sz, a);
        nbytes = (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
        mask   = (nbytes == 4) ? 32'hFFFF_FFFF : ((32'h1 << (8 * nbytes)) - 1);
        exp_rd = 32'h0;
        exp_wr = 0;
        if (!ok) exp_lat = 1;
        else if (we) begin
            exp_lat = (nbytes == 4) ? 1 : 2;
            exp_wr  = 1;
            for (int k = 0; k < nbytes; k++) rmem[a + k] = wd[8*k +: 8];
        end else begin
            exp_lat = 2;
            w = ref_word(a) & mask;
            if (!uns && nbytes < 4 && w[8*nbytes-1]) w = w | ~mask;
            exp_rd = w;
        end
        @(negedge clk);
        check({tag, ".ready"}, 32'(req_ready), 32'd1);
        req_valid = 1'b1; req_we = we; req_size = sz;
        req_unsigned = uns; req_addr = a; req_wdata = wd;
        w0 = wr_cnt;
        @(posedge clk);
        #1 req_valid = 1'b0;
        lat = 0;
        for (int i = 1; i <= 6; i++) begin
            @(negedge clk);
            if (resp_valid) begin
                lat = i;
                break;
            end
        end
        check({tag, ".lat"}, 32'(lat), 32'(exp_lat));
        check({tag, ".err"}, 32'(resp_err), 32'(!ok));
        check({tag, ".rdata"}, resp_rdata, exp_rd);
        check({tag, ".writes"}, 32'(wr_cnt - w0), 32'(exp_wr));
        @(negedge clk);
        check({tag, ".pulse"}, 32'(resp_valid), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
    end

    initial begin
        bit          saw;
        logic [1:0]  sz;
        int          a;
        rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00;
        req_unsigned = 1'b0; req_addr = 32'h0; req_wdata = 32'h0;
        #12;
        check("rst.ready", 32'(req_ready), 32'd1);
        check("rst.valid", 32'(resp_valid), 32'd0);
        check("rst.err", 32'(resp_err), 32'd0);
        check("rst.wr", 32'(mem_wr), 32'd0);
        check("rst.rdata", resp_rdata, 32'h0);
        check("rst.ra", mem_ra, 32'h0);
        check("rst.wa", mem_wa, 32'h0);
        check("rst.di", mem_di, 32'h0);
        @(negedge clk);
        rst = 1'b0;

        run("sw10", 1, SZ_WORD, 0, 32'h10, 32'hDEAD_BEEF);
        run("lw10", 0, SZ_WORD, 0, 32'h10, 32'h0);

        run("sw20", 1, SZ_WORD, 0, 32'h20, 32'h1122_3344);
        run("sb20", 1, SZ_BYTE, 0, 32'h20, 32'h0000_00AA);
        check("sb20.di", last_di, 32'h1122_33AA);
        run("lb20", 0, SZ_BYTE, 0, 32'h20, 32'h0);
        run("lbu20", 0, SZ_BYTE, 1, 32'h20, 32'h0);

        run("sw30", 1, SZ_WORD, 0, 32'h30, 32'h5566_7788);
        run("sh30", 1, SZ_HALF, 0, 32'h30, 32'h0000_8001);
        check("sh30.mem", dut_word(32'h30), 32'h5566_8001);
        run("lh30", 0, SZ_HALF, 0, 32'h30, 32'h0);
        run("lhu30", 0, SZ_HALF, 1, 32'h30, 32'h0);

        run("lwFD", 0, SZ_WORD, 0, 32'hFD, 32'h0);
        run("sz11", 1, 2'b11, 0, 32'h40, 32'h1234_5678);
        run("swFD", 1, SZ_WORD, 0, 32'hFD, 32'h1234_5678);
        run("lwFC", 0, SZ_WORD, 0, 32'hFC, 32'h0);
        run("lh21", 0, SZ_HALF, 0, 32'h21, 32'h0);
        run("lw22", 0, SZ_WORD, 0, 32'h22, 32'h0);

        run("sw50", 1, SZ_WORD, 0, 32'h50, 32'hCAFE_F00D);
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_size = SZ_BYTE;
        req_unsigned = 1'b0; req_addr = 32'h50; req_wdata = 32'h77;
        @(posedge clk);
        #1 req_valid = 1'b0;
        #1 rst = 1'b1;
        #1 check("rstrmw.wr", 32'(mem_wr), 32'd0);
        check("rstrmw.ready", 32'(req_ready), 32'd1);
        saw = 0;
        repeat (3) begin
            @(negedge clk);
            if (resp_valid) saw = 1;
        end
        check("rstrmw.noresp", 32'(saw), 32'd0);
        check("rstrmw.mem", dut_word(32'h50), 32'hCAFE_F00D);
        rst = 1'b0;
        run("lw50", 0, SZ_WORD, 0, 32'h50, 32'h0);

        for (int n = 0; n < 60; n++) begin
            sz = 2'($urandom_range(0, 3));
            a  = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 255))
                                             : int'($urandom_range(0, 252));
            run("rnd", 1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)),
                a, $urandom);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
